// File: rtl/fir_pkg.sv
// Shared types and helpers for the fir_mac datapath.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fir_state_t;

    // Side-band that travels with each product through the optional pipeline stage.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic ovr;
    } mac_tag_t;

    function automatic int unsigned prod_width(input int unsigned a_width,
                                               input int unsigned b_width);
        return a_width + b_width;
    endfunction

endpackage

// File: rtl/signed_mult.sv
// Full-precision signed multiplier; registered output stage when FIR_MAC_PIPE_EN is defined.
module signed_mult
    import fir_pkg::*;
#(
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned B_WIDTH = 16
) (
`ifdef FIR_MAC_PIPE_EN
    input  logic                                           clk,
    input  logic                                           rst_n,
`endif
    input  logic signed [A_WIDTH-1:0]                      a,
    input  logic signed [B_WIDTH-1:0]                      b,
    input  mac_tag_t                                       tag,
    output logic signed [prod_width(A_WIDTH, B_WIDTH)-1:0] prod_c,
    output mac_tag_t                                       tag_c
);

    localparam int unsigned PW = prod_width(A_WIDTH, B_WIDTH);

    logic signed [PW-1:0] full_c;

    assign full_c = PW'(a) * PW'(b);

`ifdef FIR_MAC_PIPE_EN
    logic signed [PW-1:0] prod_r;
    mac_tag_t             tag_r;

    // Product and its side-band advance together so overflow/frame markers stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0;
            tag_r  <= '0;
        end else begin
            tag_r <= tag;
            if (tag.valid) begin
                prod_r <= full_c;
            end
        end
    end

    assign prod_c = prod_r;
    assign tag_c  = tag_r;
`else
    assign prod_c = full_c;
    assign tag_c  = tag;
`endif

endmodule

// File: rtl/fir_mac.sv
// Frame-based signed multiply-accumulate with sticky overflow and valid/ready result handshake.
// Define FIR_MAC_PIPE_EN to register the product ahead of the adder (one extra cycle of latency).
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DIN_FRAC   = 15,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned COEF_FRAC  = 15,
    parameter int unsigned TAPS       = 8,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  i_sample,
    input  logic [COEF_WIDTH-1:0] i_coef,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_ovr,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_ovr,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int unsigned PW    = prod_width(DIN_WIDTH, COEF_WIDTH);
    localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    if (ACC_WIDTH < PW || TAPS < 1 || DIN_FRAC >= DIN_WIDTH || COEF_FRAC >= COEF_WIDTH) begin : g_bad_cfg
        $error("fir_mac: illegal parameter combination");
    end

    fir_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic                   accept_c;
    logic                   last_c;
    mac_tag_t               tag_in_c;
    mac_tag_t               ptag_c;
    logic signed [PW-1:0]   prod_c;
    logic signed [ACC_WIDTH-1:0] prod_ext_c;
    logic [ACC_WIDTH-1:0]   sum_c;
    logic                   add_ovr_c;

    assign accept_c = i_valid & o_ready;
    assign last_c   = (cnt == CNT_W'(TAPS - 1));

    assign tag_in_c.valid = accept_c;
    assign tag_in_c.first = (cnt == '0);
    assign tag_in_c.last  = last_c;
    assign tag_in_c.ovr   = accept_c & i_ovr;

    signed_mult #(
        .A_WIDTH (DIN_WIDTH),
        .B_WIDTH (COEF_WIDTH)
    ) u_mult (
`ifdef FIR_MAC_PIPE_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .a      (i_sample),
        .b      (i_coef),
        .tag    (tag_in_c),
        .prod_c (prod_c),
        .tag_c  (ptag_c)
    );

    // Wrapping add; overflow when like-signed addends yield an opposite-signed sum.
    assign prod_ext_c = ACC_WIDTH'(prod_c);
    assign sum_c      = o_acc + prod_ext_c;
    assign add_ovr_c  = (o_acc[ACC_WIDTH-1] == prod_ext_c[ACC_WIDTH-1]) &&
                        (sum_c[ACC_WIDTH-1] != o_acc[ACC_WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_acc   <= '0;
            o_ovr   <= 1'b0;
            o_valid <= 1'b0;
            o_ready <= 1'b0;
        end else begin
            if (accept_c) begin
                cnt <= last_c ? '0 : cnt + CNT_W'(1);
            end

            if (ptag_c.valid) begin
                o_acc <= ptag_c.first ? prod_ext_c : sum_c;
                o_ovr <= (ptag_c.first ? 1'b0 : (o_ovr | add_ovr_c)) | ptag_c.ovr;
            end

            case (state)
                ST_IDLE: begin
                    o_ready <= 1'b1;
                    if (accept_c) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                        o_ovr   <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Stop accepting once the frame's last pair is in; the result must drain first.
            if (accept_c && last_c) begin
                o_ready <= 1'b0;
            end

            if (ptag_c.valid && ptag_c.last) begin
                state   <= ST_DONE;
                o_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// Randomized self-checking bench for fir_mac: 40-bit and 32-bit accumulator instances share stimulus.
module tb_fir_mac;

`ifdef FIR_MAC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_sample;
    logic [15:0] i_coef;
    logic        i_valid;
    logic        i_ovr;
    logic        i_ready;

    logic        a_ready, a_ovr, a_valid;
    logic [39:0] a_acc;
    logic        b_ready, b_ovr, b_valid;
    logic [31:0] b_acc;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_mac #(.DIN_WIDTH(16), .DIN_FRAC(15), .COEF_WIDTH(16), .COEF_FRAC(15),
              .TAPS(4), .ACC_WIDTH(40)) dut40 (
        .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_coef(i_coef),
        .i_valid(i_valid), .o_ready(a_ready), .i_ovr(i_ovr), .o_acc(a_acc),
        .o_ovr(a_ovr), .o_valid(a_valid), .i_ready(i_ready));

    fir_mac #(.DIN_WIDTH(16), .DIN_FRAC(15), .COEF_WIDTH(16), .COEF_FRAC(15),
              .TAPS(4), .ACC_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_coef(i_coef),
        .i_valid(i_valid), .o_ready(b_ready), .i_ovr(i_ovr), .o_acc(b_acc),
        .o_ovr(b_ovr), .o_valid(b_valid), .i_ready(i_ready));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dot product as exact integers; each add is range-checked against a w-bit signed result.
    function automatic longint model(input logic [15:0] s[4], input logic [15:0] c[4],
                                     input logic ov[4], input int w, output logic ovr);
        longint lim = longint'(1) <<< (w - 1);
        longint acc = 0;
        longint t;
        ovr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = longint'($signed(s[i])) * longint'($signed(c[i]));
            if (i != 0) begin
                t = acc + t;
                if (t >= lim || t < -lim) ovr = 1'b1;
                t = t % (2 * lim);
                if (t >= lim) t = t - 2 * lim;
                if (t < -lim) t = t + 2 * lim;
            end
            acc = t;
            if (ov[i]) ovr = 1'b1;
        end
        return acc & ((longint'(1) <<< w) - 1);
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("rst_acc40",   64'(a_acc),   64'h0);
        chk("rst_acc32",   64'(b_acc),   64'h0);
        chk("rst_ovr",     64'({a_ovr, b_ovr}), 64'h0);
        chk("rst_valid",   64'({a_valid, b_valid}), 64'h0);
        chk("rst_ready",   64'({a_ready, b_ready}), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'({a_ready, b_ready}), 64'h3);
    endtask

    task automatic run_frame(input logic [15:0] s[4], input logic [15:0] c[4],
                             input logic ov[4], input bit gaps, input int stall);
        int   k = 0;
        int   guard = 0;
        int   lat;
        bit   acc_now;
        logic e40_ovr, e32_ovr;
        longint e40, e32;
        e40 = model(s, c, ov, 40, e40_ovr);
        e32 = model(s, c, ov, 32, e32_ovr);
        i_ready = 1'b0;
        while (k < 4 && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_valid  = 1'b0;
                i_sample = 16'($urandom);
                i_ovr    = 1'($urandom);
            end else begin
                i_valid  = 1'b1;
                i_sample = s[k];
                i_coef   = c[k];
                i_ovr    = ov[k];
            end
            acc_now = i_valid && a_ready;
            step();
            if (acc_now) k++;
            guard++;
        end
        chk("accepts", 64'(k), 64'd4);
        i_valid = 1'b0;
        i_ovr   = 1'b0;
        chk("ready_drain", 64'({a_ready, b_ready}), 64'h0);
        lat = 1;
        while (!a_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        chk("valid32", 64'(b_valid), 64'h1);
        chk("acc40", 64'(a_acc), 64'(e40));
        chk("ovr40", 64'(a_ovr), 64'(e40_ovr));
        chk("acc32", 64'(b_acc), 64'(e32));
        chk("ovr32", 64'(b_ovr), 64'(e32_ovr));
        for (int j = 0; j < stall; j++) begin
            i_valid  = 1'b1;
            i_sample = 16'($urandom);
            i_coef   = 16'($urandom);
            i_ovr    = 1'($urandom);
            step();
            chk("stall_valid", 64'({a_valid, b_valid}), 64'h3);
            chk("stall_ready", 64'({a_ready, b_ready}), 64'h0);
            chk("stall_acc40", 64'(a_acc), 64'(e40));
            chk("stall_acc32", 64'(b_acc), 64'(e32));
            chk("stall_ovr",   64'({a_ovr, b_ovr}), 64'({e40_ovr, e32_ovr}));
        end
        i_valid = 1'b0;
        i_ovr   = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("post_hs_valid", 64'({a_valid, b_valid}), 64'h0);
        chk("post_hs_ovr",   64'({a_ovr, b_ovr}), 64'h0);
        chk("post_hs_ready", 64'({a_ready, b_ready}), 64'h3);
    endtask

    logic [15:0] s [4];
    logic [15:0] c [4];
    logic        ov[4];

    initial begin
        i_sample = '0;
        i_coef   = '0;
        i_ovr    = 1'b0;
        do_reset();

        // Quarter-scale squares: 4 x 2^28 = 2^30.
        for (int i = 0; i < 4; i++) begin s[i] = 16'h4000; c[i] = 16'h4000; ov[i] = 1'b0; end
        run_frame(s, c, ov, 1'b0, 0);

        // (-1)x(-1) four times: wraps to zero with overflow in 32 bits.
        for (int i = 0; i < 4; i++) begin s[i] = 16'h8000; c[i] = 16'h8000; ov[i] = 1'b0; end
        run_frame(s, c, ov, 1'b0, 0);

        // Downstream stall with extra i_valid traffic.
        for (int i = 0; i < 4; i++) begin s[i] = 16'($urandom); c[i] = 16'($urandom); ov[i] = 1'b0; end
        run_frame(s, c, ov, 1'b0, 5);

        // Upstream overflow on the second pair, then a clean frame.
        for (int i = 0; i < 4; i++) begin s[i] = 16'h0100; c[i] = 16'h0200; ov[i] = (i == 1); end
        run_frame(s, c, ov, 1'b0, 0);
        ov[1] = 1'b0;
        run_frame(s, c, ov, 1'b0, 0);

        // Reset after two accepts discards the partial frame.
        i_valid  = 1'b1;
        i_sample = 16'h7fff;
        i_coef   = 16'h7fff;
        i_ovr    = 1'b1;
        step();
        step();
        do_reset();
        for (int i = 0; i < 4; i++) begin s[i] = 16'h4000; c[i] = 16'h4000; ov[i] = 1'b0; end
        run_frame(s, c, ov, 1'b0, 0);

        // Random frames with input gaps and short stalls.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 4; i++) begin
                s[i]  = 16'($urandom);
                c[i]  = 16'($urandom);
                ov[i] = ($urandom_range(0, 9) == 0);
            end
            run_frame(s, c, ov, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_mac.md
FIR_MAC -- requirements
Module: fir_mac

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16, signed sample width.
REQ-002 SHALL have parameter DIN_FRAC, default 15, sample fractional bits.
REQ-003 SHALL have parameter COEF_WIDTH, default 16, signed coefficient width.
REQ-004 SHALL have parameter COEF_FRAC, default 15, coefficient fractional bits.
REQ-005 SHALL have parameter TAPS, default 8, products per output frame; valid range 1 or more.
REQ-006 SHALL have parameter ACC_WIDTH, default 40, accumulator width; must be at least DIN_WIDTH+COEF_WIDTH.
REQ-007 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_sample, input, DIN_WIDTH, signed sample.
REQ-010 SHALL have port i_coef, input, COEF_WIDTH, signed coefficient.
REQ-011 SHALL have port i_valid, input, 1, sample/coefficient pair valid.
REQ-012 SHALL have port o_ready, output, 1, block accepts a pair.
REQ-013 SHALL have port i_ovr, input, 1, upstream overflow flag qualified by i_valid.
REQ-014 SHALL have port o_acc, output, ACC_WIDTH, dot product, fractional bits DIN_FRAC+COEF_FRAC.
REQ-015 SHALL have port o_ovr, output, 1, frame overflow flag qualified by o_valid.
REQ-016 SHALL have port o_valid, output, 1, o_acc/o_ovr valid.
REQ-017 SHALL have port i_ready, input, 1, downstream converter accepts the result.

Function
REQ-018 SHALL accept a pair only on a cycle with i_valid and o_ready both high.
REQ-019 SHALL form the full-precision signed product (DIN_WIDTH+COEF_WIDTH bits) and sign-extend it to ACC_WIDTH.
REQ-020 SHALL load the first product of a frame into the accumulator and add every later product; no rounding or saturation; the sum wraps.
REQ-021 SHALL flag add overflow when both addend signs match and the sum sign differs.
REQ-022 SHALL hold a sticky frame flag that sets on add overflow or on an accepted i_ovr.
REQ-023 SHALL run an FSM: IDLE to ACCUM on the first accept; ACCUM to DONE when the last product is added; DONE to IDLE on the o_valid and i_ready handshake.
REQ-024 SHALL count accepted pairs from 0 to TAPS-1 and wrap to 0 at the frame end.
REQ-025 SHALL drive o_ready high in IDLE and ACCUM only, low in DONE and while the pipeline drains.
REQ-026 SHALL raise o_valid the cycle after the TAPS-th accept, or two cycles after it when the product register is enabled.
REQ-027 SHALL hold o_acc, o_ovr and o_valid stable while i_ready is low.
REQ-028 SHALL clear o_valid and the sticky flag in the cycle after the handshake; o_ready reasserts that same cycle; no accept in the handshake cycle.
REQ-029 SHALL handle TAPS=1 as a single-product frame following the same timing.
REQ-030 SHALL tolerate gaps in i_valid within a frame without changing the result.

Reset
REQ-031 SHALL on rst_n low asynchronously set the state to IDLE and clear the counter, accumulator, product register and sticky flag.
REQ-032 SHALL on rst_n low drive o_acc=0, o_ovr=0, o_valid=0 and o_ready=0.
REQ-033 SHALL raise o_ready in the first clock after reset release.
REQ-034 SHALL discard a partial frame when reset asserts mid-frame.

Configuration
REQ-035 SHALL register the product before the adder when macro FIR_MAC_PIPE_EN is defined, adding 1 cycle of latency; the i_ovr flag is delayed with it.
REQ-036 SHALL feed the product combinationally into the adder when FIR_MAC_PIPE_EN is undefined.

Structure
REQ-037 SHALL place the FSM state enum and a product-width constant function in shared package fir_pkg.
REQ-038 SHALL implement the multiplier, plus the optional register, as sub-module signed_mult.

Verification (TAPS=4, 16/15 in, ACC_WIDTH=40 unless stated)
REQ-039 SHALL cover: four pairs of 0x4000 x 0x4000 -> o_acc=0x0040000000, o_ovr=0, o_valid the cycle after the 4th accept.
REQ-040 SHALL cover: ACC_WIDTH=32, four pairs of 0x8000 x 0x8000 -> o_ovr=1, o_acc=0x00000000 (wrapped).
REQ-041 SHALL cover: i_ready low 5 cycles after o_valid -> o_acc/o_ovr stable, o_ready=0, extra i_valid ignored.
REQ-042 SHALL cover: i_ovr=1 on the 2nd pair of a non-overflowing frame -> o_ovr=1; next frame o_ovr=0.
REQ-043 SHALL cover: rst_n low after 2 accepts -> all outputs 0; the next full frame of 0x4000 pairs -> 0x0040000000.
REQ-044 SHALL cover: FIR_MAC_PIPE_EN defined -> same results as REQ-039, o_valid 2 cycles after the 4th accept.
